door_lock_ctrl: RTL and testbench
=================================

# door_lock_ctrl

Multi-door successor to the single-door lock driver in the room terminal FPGA. It keeps a per-door availability flag and grants timed unlocks when an unlock is requested on an available room. It relocks as soon as the door is opened and raises an ajar alarm if the door stays open too long. It sits between the keypad/availability logic and the lock-solenoid output pins, and is replicated internally across `N_DOORS` channels.

## Interface
- `N_DOORS`, 1: number of independent door channels (1..16).
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `UNLOCK_MS`, 3000: unlock window in ms. `UNLOCK_CYC` = `CLK_HZ/1000*UNLOCK_MS`.
- `AJAR_MS`, 30000: time the door may stay open before the alarm asserts. `AJAR_CYC` = `CLK_HZ/1000*AJAR_MS`.
- `FPGA_CLK1_50`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. Deassertion is synchronous to the clock (handled externally).
- `available`  in  N_DOORS  1-cycle pulse per door; sets that door's availability flag.
- `unavailable`  in  N_DOORS  1-cycle pulse per door; clears the flag.
- `unlock_req`  in  N_DOORS  1-cycle pulse per door; unlock request from the keypad.
- `door_open`  in  N_DOORS  asynchronous door-sensor level (1 = open); 2-FF synchronised inside.
- `lock_output`  out  N_DOORS  registered; 1 = solenoid energised (door unlocked).
- `room_available`  out  N_DOORS  registered availability flag.
- `denied`  out  N_DOORS  registered 1-cycle pulse; request refused.
- `ajar_alarm`  out  N_DOORS  registered level.

## Operation
- Reset values: all outputs 0, all channels in LOCKED, timers 0, synchroniser stages 0.
- Availability flag, per door:
  - `available` sets it; `unavailable` clears it.
  - If both pulse in the same cycle, `unavailable` wins.
  - The flag updates one cycle after the pulse.
- Per-channel FSM:
  - **LOCKED** (lock=0, alarm=0, timer=0)
    - `unlock_req` & flag → UNLOCKED.
    - `unlock_req` & !flag → `denied` pulse, stay in LOCKED.
    - Synchronised `door_open` (`dso`) = 1 → OPEN. `dso` takes priority over `unlock_req`, which is then ignored with no `denied` pulse.
  - **UNLOCKED** (lock=1), timer increments each cycle. Exits, highest priority first:
    1. `unavailable` pulse → LOCKED.
    2. `dso` → OPEN, timer cleared.
    3. `unlock_req` → timer restarts at 0 (retrigger); no `denied` pulse.
    4. timer == `UNLOCK_CYC`-1 → LOCKED.
  - **OPEN** (lock=0), timer counts the ajar time.
    - `dso`=0 → LOCKED.
    - timer == `AJAR_CYC`-1 → ALARM.
    - `unlock_req` is ignored.
  - **ALARM** (lock=0, `ajar_alarm`=1).
    - `dso`=0 → LOCKED, alarm clears on the same transition.
    - `unlock_req` is ignored.
- The `flag` used in a cycle is the registered value, so an `available` pulse coincident with `unlock_req` does not grant the unlock.
- Timer:
  - One timer per channel, shared by UNLOCKED and OPEN.
  - Width `$clog2(max(UNLOCK_CYC, AJAR_CYC))`.
  - Saturates; never wraps.
  - Cleared on every state transition.
- Channels are fully independent; there is no cross-channel arbitration.
- Reset asserted mid-operation forces every channel to LOCKED with all outputs 0 immediately (asynchronous).

## Timing
- `unlock_req` sampled at edge N (granted):
  - `lock_output`=1 from N+1.
  - `lock_output`=0 from N+1+`UNLOCK_CYC`, so it is high for exactly `UNLOCK_CYC` cycles.
- Retrigger at edge M inside the window: `lock_output` stays 1 through M+`UNLOCK_CYC`, falling at M+1+`UNLOCK_CYC`.
- `denied` is high at N+1 only, for one cycle.
- `door_open` rising edge:
  - Seen as `dso` 2 cycles later.
  - State change and `lock_output` fall 1 cycle after that, i.e. 3 cycles total.
- `ajar_alarm` rises `AJAR_CYC` cycles after entry to OPEN.
  - It falls 3 cycles after `door_open` falls.
- An `unavailable` pulse during UNLOCKED drops `lock_output` on the next edge.
- No combinational input→output paths.

## Test plan
Bench parameters: `CLK_HZ`=1000, `UNLOCK_MS`=10, `AJAR_MS`=20, `N_DOORS`=2.
- **Grant:** reset; `available[0]` pulse; `unlock_req[0]` at cycle 5 → `lock_output[0]`=1 on cycles 6–15, 0 at 16; door 1 unaffected throughout.
- **Deny and priority:**
  - `unlock_req[1]` with flag 0 → `denied[1]`=1 for one cycle, `lock_output[1]` stays 0.
  - `available[1]`+`unavailable[1]` in the same cycle → `room_available[1]` stays 0.
- **Retrigger and revoke:**
  - Grant at cycle 0, re-request at cycle 7 → unlock held through cycle 17.
  - Separately, `unavailable` at cycle 4 of a window → `lock_output` 0 at cycle 5.
- **Open, ajar, alarm:**
  - Door opened during unlock → `lock_output` 0 three cycles later.
  - Door held open → `ajar_alarm`=1 twenty cycles after OPEN entry.
  - Door closed → alarm clears three cycles later, state LOCKED.
- **Reset mid-window:** `reset_n` low while unlocked with alarm on door 1 → all outputs 0 immediately; after release, `room_available` is 0 and an unlock request is denied.

Source files
------------

// File: rtl/door_lock_ctrl.sv
`default_nettype none
// ==== door_lock_ctrl : N-door timed lock driver with availability flags and ajar alarm ====
// Revision 1.0
module door_lock_ctrl #(
  parameter int N_DOORS   = 1,
  parameter int CLK_HZ    = 50_000_000,
  parameter int UNLOCK_MS = 3000,
  parameter int AJAR_MS   = 30000
) (
  input  logic               FPGA_CLK1_50,
  input  logic               reset_n,
  input  logic [N_DOORS-1:0] available,
  input  logic [N_DOORS-1:0] unavailable,
  input  logic [N_DOORS-1:0] unlock_req,
  input  logic [N_DOORS-1:0] door_open,
  output logic [N_DOORS-1:0] lock_output,
  output logic [N_DOORS-1:0] room_available,
  output logic [N_DOORS-1:0] denied,
  output logic [N_DOORS-1:0] ajar_alarm
);

  localparam int UNLOCK_CYC = CLK_HZ / 1000 * UNLOCK_MS;
  localparam int AJAR_CYC   = CLK_HZ / 1000 * AJAR_MS;
  localparam int MAX_CYC    = (UNLOCK_CYC > AJAR_CYC) ? UNLOCK_CYC : AJAR_CYC;
  localparam int TIMER_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TIMER_W-1:0] UNLOCK_LAST = TIMER_W'(UNLOCK_CYC - 1);
  localparam logic [TIMER_W-1:0] AJAR_LAST   = TIMER_W'(AJAR_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_OPEN     = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  logic [N_DOORS-1:0] sync_meta;
  logic [N_DOORS-1:0] dso;

  // Door sensors are asynchronous to the clock.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      dso       <= '0;
    end else begin
      sync_meta <= door_open;
      dso       <= sync_meta;
    end
  end

  // Clearing wins over setting when both pulse together.
  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      room_available <= '0;
    end else begin
      room_available <= (room_available | available) & ~unavailable;
    end
  end

  for (genvar d = 0; d < N_DOORS; d++) begin : g_door
    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               denied_nxt;
    logic               lock_reg;
    logic               alarm_reg;
    logic               denied_reg;

    always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      denied_nxt = 1'b0;
      case (state)
        ST_LOCKED: begin
          timer_nxt = '0;
          if (dso[d]) begin
            state_nxt = ST_OPEN;
          end else if (unlock_req[d]) begin
            if (room_available[d]) begin
              state_nxt = ST_UNLOCKED;
            end else begin
              denied_nxt = 1'b1;
            end
          end
        end
        ST_UNLOCKED: begin
          if (unavailable[d]) begin
            state_nxt = ST_LOCKED;
          end else if (dso[d]) begin
            state_nxt = ST_OPEN;
          end else if (unlock_req[d]) begin
            timer_nxt = '0;
          end else if (timer == UNLOCK_LAST) begin
            state_nxt = ST_LOCKED;
          end else if (timer != TIMER_MAX) begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_OPEN: begin
          if (!dso[d]) begin
            state_nxt = ST_LOCKED;
          end else if (timer == AJAR_LAST) begin
            state_nxt = ST_ALARM;
          end else if (timer != TIMER_MAX) begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_ALARM: begin
          if (!dso[d]) begin
            state_nxt = ST_LOCKED;
          end
        end
        default: begin
          state_nxt = ST_LOCKED;
        end
      endcase
      if (state_nxt != state) begin
        timer_nxt = '0;
      end
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
        state      <= ST_LOCKED;
        timer      <= '0;
        lock_reg   <= 1'b0;
        alarm_reg  <= 1'b0;
        denied_reg <= 1'b0;
      end else begin
        state      <= state_nxt;
        timer      <= timer_nxt;
        lock_reg   <= (state_nxt == ST_UNLOCKED);
        alarm_reg  <= (state_nxt == ST_ALARM);
        denied_reg <= denied_nxt;
      end
    end

    assign lock_output[d] = lock_reg;
    assign ajar_alarm[d]  = alarm_reg;
    assign denied[d]      = denied_reg;
  end

endmodule
`default_nettype wire

// File: tb/tb_door_lock_ctrl.sv
`default_nettype none
// tb_door_lock_ctrl: directed checks of grant, deny, retrigger, revoke, ajar alarm and reset.
module tb_door_lock_ctrl;

  localparam int N_DOORS   = 2;
  localparam int CLK_HZ    = 1000;
  localparam int UNLOCK_MS = 10;
  localparam int AJAR_MS   = 20;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N_DOORS-1:0] available;
  logic [N_DOORS-1:0] unavailable;
  logic [N_DOORS-1:0] unlock_req;
  logic [N_DOORS-1:0] door_open;
  logic [N_DOORS-1:0] lock_output;
  logic [N_DOORS-1:0] room_available;
  logic [N_DOORS-1:0] denied;
  logic [N_DOORS-1:0] ajar_alarm;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  door_lock_ctrl #(
    .N_DOORS  (N_DOORS),
    .CLK_HZ   (CLK_HZ),
    .UNLOCK_MS(UNLOCK_MS),
    .AJAR_MS  (AJAR_MS)
  ) dut (
    .FPGA_CLK1_50  (clk),
    .reset_n       (reset_n),
    .available     (available),
    .unavailable   (unavailable),
    .unlock_req    (unlock_req),
    .door_open     (door_open),
    .lock_output   (lock_output),
    .room_available(room_available),
    .denied        (denied),
    .ajar_alarm    (ajar_alarm)
  );

  task automatic check(input string tag, input logic [N_DOORS-1:0] got,
                       input logic [N_DOORS-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive pulses for one cycle; returns in the cycle after they were sampled.
  task automatic pulse(input logic [N_DOORS-1:0] av, input logic [N_DOORS-1:0] un,
                       input logic [N_DOORS-1:0] rq);
    available   = av;
    unavailable = un;
    unlock_req  = rq;
    step(1);
    available   = '0;
    unavailable = '0;
    unlock_req  = '0;
  endtask

  initial begin
    reset_n     = 1'b0;
    available   = '0;
    unavailable = '0;
    unlock_req  = '0;
    door_open   = '0;
    step(2);
    check("rst_lock", lock_output, 2'b00);
    check("rst_avail", room_available, 2'b00);
    check("rst_denied", denied, 2'b00);
    check("rst_alarm", ajar_alarm, 2'b00);
    reset_n = 1'b1;
    step(1);

    // Grant: lock high for exactly 10 cycles, door 1 untouched
    pulse(2'b01, 2'b00, 2'b00);
    check("grant_flag", room_available, 2'b01);
    pulse(2'b00, 2'b00, 2'b01);
    check("grant_no_deny", denied, 2'b00);
    for (int i = 0; i < 10; i++) begin
      check("grant_lock", lock_output, 2'b01);
      step(1);
    end
    check("grant_expire", lock_output, 2'b00);

    // Deny on unavailable door, and unavailable wins over available
    pulse(2'b00, 2'b00, 2'b10);
    check("deny_pulse", denied, 2'b10);
    check("deny_lock", lock_output, 2'b00);
    step(1);
    check("deny_once", denied, 2'b00);
    pulse(2'b10, 2'b10, 2'b00);
    check("both_flag", room_available, 2'b01);
    step(1);
    check("both_flag_hold", room_available, 2'b01);

    // Retrigger: grant at cycle 0, re-request at cycle 7, held through 17
    pulse(2'b00, 2'b00, 2'b01);
    check("retrig_start", lock_output, 2'b01);
    step(6);
    check("retrig_pre", lock_output, 2'b01);
    pulse(2'b00, 2'b00, 2'b01);
    check("retrig_no_deny", denied, 2'b00);
    for (int i = 0; i < 10; i++) begin
      check("retrig_hold", lock_output, 2'b01);
      step(1);
    end
    check("retrig_expire", lock_output, 2'b00);

    // Revoke: unavailable at cycle 4 drops lock at cycle 5
    pulse(2'b00, 2'b00, 2'b01);
    step(3);
    check("revoke_pre", lock_output, 2'b01);
    pulse(2'b00, 2'b01, 2'b00);
    check("revoke_lock", lock_output, 2'b00);
    check("revoke_flag", room_available, 2'b00);

    // Open during unlock, ajar alarm, close
    pulse(2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b00, 2'b01);
    step(1);
    door_open = 2'b01;
    step(2);
    check("open_pre", lock_output, 2'b01);
    step(1);
    check("open_relock", lock_output, 2'b00);
    step(5);
    pulse(2'b00, 2'b00, 2'b01);
    check("open_req_nodeny", denied, 2'b00);
    check("open_req_nolock", lock_output, 2'b00);
    step(13);
    check("ajar_pre", ajar_alarm, 2'b00);
    step(1);
    check("ajar_set", ajar_alarm, 2'b01);
    step(2);
    door_open = 2'b00;
    step(2);
    check("ajar_hold", ajar_alarm, 2'b01);
    step(1);
    check("ajar_clear", ajar_alarm, 2'b00);
    pulse(2'b00, 2'b00, 2'b01);
    check("relocked_grant", lock_output, 2'b01);

    // Reset mid-window with door 1 in alarm
    door_open = 2'b10;
    step(23);
    check("d1_alarm", ajar_alarm, 2'b10);
    pulse(2'b00, 2'b00, 2'b01);
    check("d0_unlocked", lock_output, 2'b01);
    reset_n = 1'b0;
    #1;
    check("async_rst_lock", lock_output, 2'b00);
    check("async_rst_alarm", ajar_alarm, 2'b00);
    check("async_rst_avail", room_available, 2'b00);
    check("async_rst_denied", denied, 2'b00);
    door_open = 2'b00;
    step(2);
    reset_n = 1'b1;
    step(1);
    check("post_rst_avail", room_available, 2'b00);
    pulse(2'b00, 2'b00, 2'b01);
    check("post_rst_deny", denied, 2'b01);
    check("post_rst_lock", lock_output, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
